// File: rtl/parity_pkg.sv
// parity_pkg: shared FSM state type, error-counter ceiling and counter sizing helper.
package parity_pkg;
  typedef enum logic {ST_DATA, ST_CHECK} state_t;
  localparam logic [7:0] ERR_CNT_MAX = 8'd255;
  function automatic int cnt_width(input int frame_bits);
    return frame_bits > 1 ? $clog2(frame_bits) : 1;
  endfunction
endpackage

// File: rtl/parity_framer_if.sv
// parity_framer_if: beat input and frame status bundle between deserialiser and framer.
interface parity_framer_if #(parameter int LANES = 4);
  logic clear;
  logic in_valid;
  logic [LANES-1:0] in_bits;
  logic [LANES-1:0] parity;
  logic in_check;
  logic frame_done;
  logic [LANES-1:0] parity_err;
  logic [7:0] err_count;
  modport master(output clear, in_valid, in_bits, input parity, in_check, frame_done, parity_err, err_count);
  modport slave(input clear, in_valid, in_bits, output parity, in_check, frame_done, parity_err, err_count);
endinterface

// File: rtl/parity_lane.sv
// parity_lane: one lane's parity accumulator, output mux and received-parity compare.
module parity_lane
  import parity_pkg::*;
#(
  parameter bit ODD = 1'b0,
  parameter bit MEALY_OUT = 1'b0
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   clear,
  input  state_t state,
  input  logic   in_valid,
  input  logic   in_bit,
  output logic   parity,
  output logic   mismatch
);
  logic acc;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) acc <= 1'b0;
    else if (clear) acc <= 1'b0;
    else if (in_valid) acc <= state == ST_DATA ? acc ^ in_bit : 1'b0;
  // The parity beat is never folded into the visible parity, even in Mealy mode.
  always_comb begin
    mismatch = (acc ^ ODD) != in_bit;
    parity = acc ^ ODD ^ (MEALY_OUT && in_valid && state == ST_DATA && in_bit);
  end
endmodule

// File: rtl/parity_framer.sv
// parity_framer: multi-lane serial parity generator/checker with framing FSM and
// saturating frame-error counter.
module parity_framer
  import parity_pkg::*;
#(
  parameter int LANES = 4,
  parameter int FRAME_BITS = 8,
  parameter bit ODD = 1'b0,
  parameter bit MEALY_OUT = 1'b0
) (
  input logic clk,
  input logic reset_n,
  parity_framer_if.slave bus
);
  localparam int CW = cnt_width(FRAME_BITS);
  localparam logic [CW-1:0] LAST = CW'(FRAME_BITS - 1);
  state_t state, state_nx;
  logic [CW-1:0] bit_cnt, bit_cnt_nx;
  logic [LANES-1:0] mism;
  logic last, check_beat;
  always_comb begin
    last = bit_cnt == LAST;
    check_beat = bus.in_valid && state == ST_CHECK;
    state_nx = !bus.in_valid ? state : state == ST_CHECK ? ST_DATA : last ? ST_CHECK : ST_DATA;
    bit_cnt_nx = bus.in_valid && state == ST_DATA ? (last ? '0 : bit_cnt + 1'b1) : bit_cnt;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= ST_DATA;
      bit_cnt <= '0;
      bus.frame_done <= 1'b0;
      bus.parity_err <= '0;
      bus.err_count <= '0;
    end else if (bus.clear) begin
      state <= ST_DATA;
      bit_cnt <= '0;
      bus.frame_done <= 1'b0;
      bus.parity_err <= '0;
      bus.err_count <= '0;
    end else begin
      state <= state_nx;
      bit_cnt <= bit_cnt_nx;
      bus.frame_done <= check_beat;
      if (check_beat) begin
        bus.parity_err <= mism;
        if (|mism && bus.err_count != ERR_CNT_MAX) bus.err_count <= bus.err_count + 1'b1;
      end
    end
  assign bus.in_check = state == ST_CHECK;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    parity_lane #(.ODD(ODD), .MEALY_OUT(MEALY_OUT)) u_lane (
      .clk(clk),
      .reset_n(reset_n),
      .clear(bus.clear),
      .state(state),
      .in_valid(bus.in_valid),
      .in_bit(bus.in_bits[i]),
      .parity(bus.parity[i]),
      .mismatch(mism[i])
    );
  end
endmodule
